// File: rtl/nvdla_mcif_pkg.sv
// Shared MCIF read-request definitions: default field widths, pd layout and request struct.
package nvdla_mcif_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int SIZE_W_DEF  = 15;
    localparam int PD_ADDR_LSB = 0;
    localparam int PD_SIZE_LSB = ADDR_W_DEF;
    localparam int PD_W_DEF    = ADDR_W_DEF + SIZE_W_DEF;

    // size holds atoms-1; pd = {size, addr}
    typedef struct packed {
        logic [SIZE_W_DEF-1:0] size;
        logic [ADDR_W_DEF-1:0] addr;
    } rd_req_t;

endpackage

// File: rtl/nvdla_mcif_cdt_cnt.sv
// Up/down credit counter bounded at MAX, with a sticky flag for a return that would exceed MAX.
module nvdla_mcif_cdt_cnt
    import nvdla_mcif_pkg::*;
#(
    parameter int MAX   = 256,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic [CNT_W-1:0] dec_val,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    logic [CNT_W:0] nxt;
    logic           ovf_hit;

    always_comb begin
        ovf_hit = inc && !dec && (cnt == CNT_W'(MAX));
        nxt     = {1'b0, cnt} + (CNT_W + 1)'(inc) - (dec ? {1'b0, dec_val} : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= CNT_W'(MAX);
            overflow <= 1'b0;
        end else if (ovf_hit) begin
            overflow <= 1'b1;
        end else if (nxt > (CNT_W + 1)'(MAX)) begin
            cnt <= CNT_W'(MAX);
        end else begin
            cnt <= nxt[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/nvdla_mcif_rd_cdt_gate.sv
// Read-request credit gate: forwards a client request only when the latency FIFO can absorb its atoms.
module nvdla_mcif_rd_cdt_gate
    import nvdla_mcif_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SIZE_W    = SIZE_W_DEF,
    parameter int LAT_DEPTH = 256,
    parameter int CNT_W     = $clog2(LAT_DEPTH + 1)
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic                     dma2gate_rd_req_valid,
    output logic                     dma2gate_rd_req_ready,
    input  logic [ADDR_W+SIZE_W-1:0] dma2gate_rd_req_pd,
    output logic                     gate2mcif_rd_req_valid,
    input  logic                     gate2mcif_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0] gate2mcif_rd_req_pd,
    input  logic                     rd_cdt_lat_fifo_pop,
    output logic [CNT_W-1:0]         credit_avail,
    output logic [31:0]              stall_cnt,
    output logic                     err_oversize,
    output logic                     err_cdt_overflow
);

    localparam int PD_W   = ADDR_W + SIZE_W;
    localparam int NEED_W = ((SIZE_W > CNT_W) ? SIZE_W : CNT_W) + 1;

    logic [SIZE_W-1:0] size_p0;
    logic [NEED_W-1:0] need_p0;
    logic [CNT_W-1:0]  need_eff_p0;
    logic              oversize_p0;
    logic              slot_free_p0;
    logic              cdt_ok_p0;
    logic              accept_p0;
    logic              vld_p1;
    logic [PD_W-1:0]   pd_p1;

    // Stage p0: credit check on the incoming request against the registered count
    always_comb begin
        size_p0      = dma2gate_rd_req_pd[ADDR_W +: SIZE_W];
        need_p0      = NEED_W'(size_p0) + NEED_W'(1);
        oversize_p0  = need_p0 > NEED_W'(LAT_DEPTH);
        need_eff_p0  = oversize_p0 ? CNT_W'(LAT_DEPTH) : CNT_W'(need_p0);
        slot_free_p0 = !vld_p1 || gate2mcif_rd_req_ready;
        cdt_ok_p0    = credit_avail >= need_eff_p0;
        accept_p0    = dma2gate_rd_req_valid && slot_free_p0 && cdt_ok_p0;
    end

    assign dma2gate_rd_req_ready = slot_free_p0 && cdt_ok_p0;

    nvdla_mcif_cdt_cnt #(
        .MAX   (LAT_DEPTH),
        .CNT_W (CNT_W)
    ) u_cdt_cnt (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .dec      (accept_p0),
        .dec_val  (need_eff_p0),
        .inc      (rd_cdt_lat_fifo_pop),
        .cnt      (credit_avail),
        .overflow (err_cdt_overflow)
    );

    // Stage p1: output request register toward MCIF
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            vld_p1 <= 1'b0;
            pd_p1  <= '0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            pd_p1  <= dma2gate_rd_req_pd;
        end else if (gate2mcif_rd_req_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign gate2mcif_rd_req_valid = vld_p1;
    assign gate2mcif_rd_req_pd    = pd_p1;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            stall_cnt    <= '0;
            err_oversize <= 1'b0;
        end else begin
            if (dma2gate_rd_req_valid && slot_free_p0 && !cdt_ok_p0 && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (accept_p0 && oversize_p0)
                err_oversize <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nvdla_mcif_rd_cdt_gate.sv
// Directed bench for nvdla_mcif_rd_cdt_gate with LAT_DEPTH=256 and default field widths.
module tb_nvdla_mcif_rd_cdt_gate;
    import nvdla_mcif_pkg::*;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;
    localparam int LAT    = 256;
    localparam int CNT_W  = 9;
    localparam int PD_W   = ADDR_W + SIZE_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PD_W-1:0]  in_pd = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PD_W-1:0]  out_pd;
    logic             pop = 1'b0;
    logic [CNT_W-1:0] credit;
    logic [31:0]      stalls;
    logic             e_over;
    logic             e_ovf;

    int n_cmp = 0;
    int n_fail = 0;

    nvdla_mcif_rd_cdt_gate #(
        .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .LAT_DEPTH(LAT), .CNT_W(CNT_W)
    ) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .dma2gate_rd_req_valid  (in_valid),
        .dma2gate_rd_req_ready  (in_ready),
        .dma2gate_rd_req_pd     (in_pd),
        .gate2mcif_rd_req_valid (out_valid),
        .gate2mcif_rd_req_ready (out_ready),
        .gate2mcif_rd_req_pd    (out_pd),
        .rd_cdt_lat_fifo_pop    (pop),
        .credit_avail           (credit),
        .stall_cnt              (stalls),
        .err_oversize           (e_over),
        .err_cdt_overflow       (e_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [PD_W-1:0] mk(input int size, input logic [63:0] addr);
        rd_req_t r;
        r.size = SIZE_W'(size);
        r.addr = addr;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_pd     = '0;
        pop       = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++; if (credit !== 9'd256) begin n_fail++; $display("FAIL reset_credit: got %0d want 256", credit); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_pd !== '0) begin n_fail++; $display("FAIL reset_pd: got %h want 0", out_pd); end
        n_cmp++; if (stalls !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stalls); end
        n_cmp++; if ({e_over, e_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {e_over, e_ovf}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [PD_W-1:0] req;
        do_reset();
        req = mk(7, 64'h0000_1234_5678_9ABC);
        in_valid = 1'b1;
        in_pd    = req;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pd !== req) begin n_fail++; $display("FAIL single_pd: got %h want %h", out_pd, req); end
        n_cmp++; if (credit !== 9'd248) begin n_fail++; $display("FAIL single_credit: got %0d want 248", credit); end
    endtask

    task automatic test_exhaust();
        int acc;
        logic [PD_W-1:0] req;
        do_reset();
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_pd    = mk(7, 64'(i * 64));
            #1;
            if (in_ready === 1'b1) acc++;
            step();
        end
        n_cmp++; if (acc !== 32) begin n_fail++; $display("FAIL exhaust_accepts: got %0d want 32", acc); end
        n_cmp++; if (credit !== 9'd0) begin n_fail++; $display("FAIL exhaust_credit: got %0d want 0", credit); end
        req   = mk(7, 64'hABC0);
        in_pd = req;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_stall_ready: got %b want 0", in_ready); end
        step(); step(); step();
        n_cmp++; if (stalls !== 32'd3) begin n_fail++; $display("FAIL exhaust_stall_cnt: got %0d want 3", stalls); end
        pop = 1'b1;
        for (int i = 0; i < 8; i++) step();
        pop = 1'b0;
        n_cmp++; if (credit !== 9'd8) begin n_fail++; $display("FAIL exhaust_pop_credit: got %0d want 8", credit); end
        n_cmp++; if (stalls !== 32'd11) begin n_fail++; $display("FAIL exhaust_stall_cnt2: got %0d want 11", stalls); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL exhaust_release_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_pd !== req || out_valid !== 1'b1) begin n_fail++; $display("FAIL exhaust_33rd_out: got %h/%b want %h/1", out_pd, out_valid, req); end
        n_cmp++; if (credit !== 9'd0 || stalls !== 32'd11) begin n_fail++; $display("FAIL exhaust_after: got %0d/%0d want 0/11", credit, stalls); end
    endtask

    task automatic test_simul_pop();
        do_reset();
        in_valid = 1'b1;
        in_pd    = mk(245, 64'h100);
        step();
        n_cmp++; if (credit !== 9'd10) begin n_fail++; $display("FAIL simul_setup10: got %0d want 10", credit); end
        in_pd = mk(9, 64'h200);
        pop   = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready10: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        pop      = 1'b0;
        n_cmp++; if (credit !== 9'd1) begin n_fail++; $display("FAIL simul_net: got %0d want 1", credit); end

        do_reset();
        in_valid = 1'b1;
        in_pd    = mk(246, 64'h300);
        step();
        n_cmp++; if (credit !== 9'd9) begin n_fail++; $display("FAIL simul_setup9: got %0d want 9", credit); end
        in_pd = mk(9, 64'h400);
        pop   = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_no_bypass: got %b want 0", in_ready); end
        step();
        pop = 1'b0;
        n_cmp++; if (credit !== 9'd10) begin n_fail++; $display("FAIL simul_pop_only: got %0d want 10", credit); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_next_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (credit !== 9'd0) begin n_fail++; $display("FAIL simul_final: got %0d want 0", credit); end
    endtask

    task automatic test_backpressure();
        logic [PD_W-1:0] a;
        logic [PD_W-1:0] b;
        do_reset();
        a = mk(0, 64'hAAAA);
        b = mk(0, 64'hBBBB);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pd     = a;
        step();
        in_pd = b;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_pd !== a || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b pd=%h r=%b want v=1 pd=%h r=0", i, out_valid, out_pd, in_ready, a);
            end
            step();
        end
        n_cmp++; if (stalls !== 32'd0) begin n_fail++; $display("FAIL bp_stall: got %0d want 0", stalls); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_pd !== b) begin n_fail++; $display("FAIL bp_next: got %b/%h want 1/%h", out_valid, out_pd, b); end
        n_cmp++; if (credit !== 9'd254) begin n_fail++; $display("FAIL bp_credit: got %0d want 254", credit); end
    endtask

    task automatic test_oversize();
        logic [PD_W-1:0] big;
        do_reset();
        in_valid = 1'b1;
        in_pd    = mk(9, 64'h10);
        step();
        big   = mk(299, 64'hF000);
        in_pd = big;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL over_stall: got %b want 0", in_ready); end
        pop = 1'b1;
        for (int i = 0; i < 10; i++) step();
        pop = 1'b0;
        n_cmp++; if (credit !== 9'd256 || e_over !== 1'b0) begin n_fail++; $display("FAIL over_full: got %0d/%b want 256/0", credit, e_over); end
        n_cmp++; if (stalls !== 32'd10) begin n_fail++; $display("FAIL over_stall_cnt: got %0d want 10", stalls); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL over_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (credit !== 9'd0 || e_over !== 1'b1) begin n_fail++; $display("FAIL over_issue: got %0d/%b want 0/1", credit, e_over); end
        n_cmp++; if (out_pd !== big) begin n_fail++; $display("FAIL over_pd: got %h want %h", out_pd, big); end
        step(); step();
        n_cmp++; if (e_over !== 1'b1) begin n_fail++; $display("FAIL over_sticky: got %b want 1", e_over); end
    endtask

    task automatic test_overflow_reset();
        do_reset();
        pop = 1'b1;
        step();
        pop = 1'b0;
        n_cmp++; if (credit !== 9'd256 || e_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %0d/%b want 256/1", credit, e_ovf); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pd     = mk(3, 64'h40);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || credit !== 9'd252 || e_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_inflight: got %b/%0d/%b want 1/252/1", out_valid, credit, e_ovf);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || credit !== 9'd256) begin n_fail++; $display("FAIL rst_async: got %b/%0d want 0/256", out_valid, credit); end
        n_cmp++; if (e_ovf !== 1'b0 || out_pd !== '0) begin n_fail++; $display("FAIL rst_clear: got %b/%h want 0/0", e_ovf, out_pd); end
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_exhaust();
        test_simul_pop();
        test_backpressure();
        test_oversize();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
